// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory request/response, execute redirect,
// decode valid/ready handshake and fault report.
interface pc_fetch_sequencer_if;
    // fetch_pc is combinational from the PC register; fetch_instr/fetch_inv answer it the same cycle.
    // inst_*: an entry moves on a clock edge where inst_valid && inst_ready; inst_valid never
    // depends on inst_ready, and inst_pc/inst_data stay stable while inst_valid is high and unaccepted.
    logic [63:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_inv;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] inst_pc;
    logic [31:0] inst_data;
    logic        fault;
    logic [63:0] fault_pc;

    modport master (
        output fetch_pc,
        input  fetch_instr,
        input  fetch_inv,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_pc,
        output inst_data,
        output fault,
        output fault_pc
    );

    modport slave (
        input  fetch_pc,
        output fetch_instr,
        output fetch_inv,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_pc,
        input  inst_data,
        input  fault,
        input  fault_pc
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch buffer: fetches one word per cycle into a DEPTH-entry FIFO, handles
// redirects and invalid-address faults. Optional perf counters under FETCH_PERF_CNT_EN.
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_fetch_sequencer_if.master  bus,
    output logic [1:0]            o_dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]           perf_fetched,
    output logic [63:0]           perf_stall
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]       r_state;
    logic [63:0]      r_pc;
    logic [63:0]      r_fault_pc;
    logic [63:0]      r_fifo_pc   [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [1:0]       w_state_nxt;
    logic [63:0]      w_pc_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic             w_full;

    // Fullness is judged on the start-of-cycle count; a same-cycle pop never frees a slot for a push.
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = (r_count != '0) && bus.inst_ready && !bus.redirect_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_capture   = 1'b0;
        if (bus.redirect_valid) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = bus.redirect_pc;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_full) begin
                        w_state_nxt = ST_STALL;
                    end else if (bus.fetch_inv) begin
                        w_state_nxt = ST_FAULT;
                        w_capture   = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_pc + 64'd4;
                    end
                end
                ST_STALL: begin
                    if (!w_full) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_fault_pc <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture) begin
                r_fault_pc <= r_pc;
            end
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]   <= r_pc;
                r_fifo_data[r_wr_ptr] <= bus.fetch_instr;
            end
            // A redirect flushes the FIFO; the discarded response and ignored pop have no effect.
            if (bus.redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] r_perf_fetched;
    logic [63:0] r_perf_stall;

    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 64'd1;
            end
            if (r_state != ST_RUN) begin
                r_perf_stall <= r_perf_stall + 64'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

    assign bus.fetch_pc   = r_pc;
    assign bus.inst_valid = (r_count != '0);
    assign bus.inst_pc    = r_fifo_pc[r_rd_ptr];
    assign bus.inst_data  = r_fifo_data[r_rd_ptr];
    assign bus.fault      = (r_state == ST_FAULT);
    assign bus.fault_pc   = r_fault_pc;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios then random redirect/ready/reset traffic,
// all compared against a queue-based model of the fetch rules.
module tb_pc_fetch_sequencer;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_stall;
`endif

    always #5 clk = ~clk;

    pc_fetch_sequencer_if bus_if();

    pc_fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    // Instruction memory: address 0 holds ADD; 0x1000-0x1FFF and misaligned addresses are invalid.
    function automatic logic [31:0] mem_instr(input logic [63:0] pc);
        if (pc == 64'h0) return 32'h00550533;
        return (pc[31:0] * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    function automatic logic mem_inv(input logic [63:0] pc);
        return (pc[1:0] != 2'b00) || (pc >= 64'h1000 && pc < 64'h2000);
    endfunction

    always_comb begin
        bus_if.fetch_instr = mem_instr(bus_if.fetch_pc);
        bus_if.fetch_inv   = mem_inv(bus_if.fetch_pc);
    end

    typedef enum int {M_FETCHING, M_WAIT_ROOM, M_HALTED} mode_t;

    logic [95:0] m_q[$];
    logic [63:0] m_pc;
    logic [63:0] m_fault_pc;
    logic [63:0] m_fetched;
    logic [63:0] m_stalled;
    mode_t       m_mode;
    int          n_checks;
    int          n_fail;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rv, input logic [63:0] rpc, input logic rdy, input logic rst);
        int cnt;
        if (rst) begin
            m_q.delete();
            m_pc       = RESET_PC;
            m_mode     = M_FETCHING;
            m_fault_pc = 64'h0;
            m_fetched  = 64'h0;
            m_stalled  = 64'h0;
            return;
        end
        if (m_mode != M_FETCHING) m_stalled++;
        if (rv) begin
            m_q.delete();
            m_pc   = rpc;
            m_mode = M_FETCHING;
            return;
        end
        cnt = m_q.size();
        if (cnt > 0 && rdy) void'(m_q.pop_front());
        case (m_mode)
            M_FETCHING: begin
                if (cnt == DEPTH) begin
                    m_mode = M_WAIT_ROOM;
                end else if (mem_inv(m_pc)) begin
                    m_fault_pc = m_pc;
                    m_mode     = M_HALTED;
                end else begin
                    m_q.push_back({m_pc, mem_instr(m_pc)});
                    m_fetched++;
                    m_pc = m_pc + 64'd4;
                end
            end
            M_WAIT_ROOM: if (cnt < DEPTH) m_mode = M_FETCHING;
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        check_val("fetch_pc", bus_if.fetch_pc, m_pc);
        check_val("inst_valid", 64'(bus_if.inst_valid), 64'(m_q.size() != 0));
        check_val("fault", 64'(bus_if.fault), 64'(m_mode == M_HALTED));
        check_val("fault_pc", bus_if.fault_pc, m_fault_pc);
        if (m_q.size() != 0) begin
            check_val("inst_pc", bus_if.inst_pc, m_q[0][95:32]);
            check_val("inst_data", 64'(bus_if.inst_data), 64'(m_q[0][31:0]));
        end
`ifdef FETCH_PERF_CNT_EN
        check_val("perf_fetched", perf_fetched, m_fetched);
        check_val("perf_stall", perf_stall, m_stalled);
`endif
    endtask

    // One clock: drive at the falling edge, advance model at the rising edge, compare 1 time unit later.
    task automatic cycle(input logic rv, input logic [63:0] rpc, input logic rdy, input logic rst);
        @(negedge clk);
        reset                 = rst;
        bus_if.redirect_valid = rv;
        bus_if.redirect_pc    = rpc;
        bus_if.inst_ready     = rdy;
        @(posedge clk);
        model_step(rv, rpc, rdy, rst);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, rdy, 1'b0);
    endtask

    logic [63:0] tgt;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 64'h0;
        bus_if.inst_ready     = 1'b0;

        // Reset values and first fetches
        cycle(1'b0, 64'h0, 1'b1, 1'b1);
        cycle(1'b0, 64'h0, 1'b1, 1'b1);
        check_val("rst_valid", 64'(bus_if.inst_valid), 64'h0);
        check_val("rst_fault", 64'(bus_if.fault), 64'h0);
        check_val("rst_fetch_pc", bus_if.fetch_pc, RESET_PC);
        check_val("rst_inst_pc", bus_if.inst_pc, 64'h0);
        check_val("rst_inst_data", 64'(bus_if.inst_data), 64'h0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check_val("t1_valid", 64'(bus_if.inst_valid), 64'h1);
        check_val("t1_pc0", bus_if.inst_pc, 64'h0);
        check_val("t1_add", 64'(bus_if.inst_data), 64'h00550533);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check_val("t1_pc4", bus_if.inst_pc, 64'h4);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check_val("t1_pc8", bus_if.inst_pc, 64'h8);

        // Backpressure fills the FIFO and stalls
        cycle(1'b0, 64'h0, 1'b0, 1'b1);
        idle(7, 1'b0);
        check_val("t2_hold_pc", bus_if.fetch_pc, 64'h10);
        check_val("t2_head", bus_if.inst_pc, 64'h0);
        idle(1, 1'b1);
        check_val("t2_drain1", bus_if.inst_pc, 64'h4);
        idle(6, 1'b1);

        // Redirect with three queued entries
        cycle(1'b0, 64'h0, 1'b0, 1'b1);
        idle(3, 1'b0);
        cycle(1'b1, 64'h18, 1'b1, 1'b0);
        check_val("t3_flush", 64'(bus_if.inst_valid), 64'h0);
        check_val("t3_fetch_pc", bus_if.fetch_pc, 64'h18);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check_val("t3_target", bus_if.inst_pc, 64'h18);

        // Fault at 0x1000, drain, recover by redirect
        cycle(1'b1, 64'hFF8, 1'b0, 1'b0);
        idle(3, 1'b0);
        check_val("t4_fault", 64'(bus_if.fault), 64'h1);
        check_val("t4_fault_pc", bus_if.fault_pc, 64'h1000);
        idle(2, 1'b1);
        check_val("t4_drained", 64'(bus_if.inst_valid), 64'h0);
        cycle(1'b1, 64'h4, 1'b1, 1'b0);
        check_val("t4_cleared", 64'(bus_if.fault), 64'h0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check_val("t4_resume", bus_if.inst_pc, 64'h4);

        // Misaligned redirect
        cycle(1'b1, 64'h6, 1'b1, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check_val("t5_fault_pc", bus_if.fault_pc, 64'h6);

        // Reset while faulted with queued entries
        cycle(1'b1, 64'hFF4, 1'b0, 1'b0);
        idle(4, 1'b0);
        check_val("t6_pre_fault", 64'(bus_if.fault), 64'h1);
        cycle(1'b0, 64'h0, 1'b0, 1'b1);
        check_val("t6_valid", 64'(bus_if.inst_valid), 64'h0);
        check_val("t6_fault", 64'(bus_if.fault), 64'h0);
        check_val("t6_fetch_pc", bus_if.fetch_pc, RESET_PC);

        // Random traffic, including PC wrap past 2^64
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 4))
                0: tgt = 64'($urandom_range(0, 63)) << 2;
                1: tgt = 64'hFF0 + (64'($urandom_range(0, 3)) << 2);
                2: tgt = 64'($urandom_range(0, 255));
                3: tgt = 64'hFFFF_FFFF_FFFF_FFF0 + (64'($urandom_range(0, 3)) << 2);
                default: tgt = 64'h2000 + (64'($urandom_range(0, 15)) << 2);
            endcase
            cycle($urandom_range(0, 9) == 0, tgt, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
